// File: rtl/score_keeper.sv
// score_keeper
//   Score, line and level bookkeeping downstream of the board block, plus the
//   gravity tick generator for the game controller.
//
//   Each validate_done with 1..4 cleared lines adds the base points
//   (40/100/300/1200) level+1 times. Each add is one 6-digit BCD add per
//   cycle, and the score saturates at 999999. A one-cycle LEVELUP step then
//   updates total_lines (saturates at 999) and the level (saturates at
//   MAX_LEVEL). A validate_done that arrives while the FSM is working is
//   held in a one-deep pending slot.
//
//   Optional build macro SOFT_DROP_SCORE_EN: each gravity tick taken with
//   soft_drop high while the FSM idles adds one point to the score.
//
// Ports
//   clk, rst       clock, asynchronous active-high reset
//   new_game       clears score/lines/level/pending/gravity, FSM to IDLE
//   game_active    enables the gravity counter
//   soft_drop      selects SOFT_INTERVAL as the gravity interval
//   validate_done  end-of-validate pulse from the board
//   lines_cleared  rows removed in that validate (0..4)
//   score_bcd      six BCD digits, [23:20] most significant
//   total_lines    binary line total, saturating at 999
//   level          current level
//   gravity_tick   one-cycle drop pulse
//   busy           high while a score add is in progress
//   score_done     one-cycle pulse when a validate has been fully scored
module score_keeper #(
  parameter int unsigned BASE_INTERVAL   = 32'd50000000,
  parameter int unsigned STEP_INTERVAL   = 32'd3000000,
  parameter int unsigned MIN_INTERVAL    = 32'd5000000,
  parameter int unsigned SOFT_INTERVAL   = 32'd2500000,
  parameter int unsigned LINES_PER_LEVEL = 32'd10,
  parameter int unsigned MAX_LEVEL       = 32'd15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        new_game,
  input  logic        game_active,
  input  logic        soft_drop,
  input  logic        validate_done,
  input  logic [2:0]  lines_cleared,
  output logic [23:0] score_bcd,
  output logic [9:0]  total_lines,
  output logic [3:0]  level,
  output logic        gravity_tick,
  output logic        busy,
  output logic        score_done
);

  localparam int unsigned GRAV_MAX_A = (BASE_INTERVAL > SOFT_INTERVAL) ? BASE_INTERVAL : SOFT_INTERVAL;
  localparam int unsigned GRAV_MAX   = (GRAV_MAX_A > MIN_INTERVAL) ? GRAV_MAX_A : MIN_INTERVAL;
  localparam int          CNT_W      = $clog2(GRAV_MAX + 32'd1);
  // lines_in_level stays below LINES_PER_LEVEL, so +4 lines must fit before the wrap
  localparam int          LIL_W      = $clog2(LINES_PER_LEVEL + 32'd5);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ADD, S_LEVELUP} state_t;

  state_t             r_state;
  logic [2:0]         r_n;
  logic [4:0]         r_rep;
  logic [23:0]        r_addend;
  logic [23:0]        r_score;
  logic [9:0]         r_lines;
  logic [3:0]         r_level;
  logic [LIL_W-1:0]   r_lil;
  logic               r_pend_v;
  logic [2:0]         r_pend_n;
  logic               r_busy;
  logic               r_score_done;
  logic               r_tick;
  logic [CNT_W-1:0]   r_grav_cnt;

  logic               w_take;
  logic [2:0]         w_take_n;
  logic               w_take_scores;
  logic [31:0]        w_level_dec;
  logic [31:0]        w_interval;
  logic               w_tick_hit;
  logic [10:0]        w_lines_sum;
  logic [LIL_W-1:0]   w_lil_sum;
  logic               w_soft_pt;

  // Six-digit BCD add; bit 24 is the carry out of the top digit.
  function automatic logic [24:0] bcd_add6(input logic [23:0] a, input logic [23:0] b);
    logic [23:0] sum;
    logic        c;
    logic [4:0]  d;
    c = 1'b0;
    sum = 24'h000000;
    for (int i = 0; i < 6; i++) begin
      d = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'b0000, c};
      d = (d > 5'd9) ? (d + 5'd6) : d;
      sum[4*i +: 4] = d[3:0];
      c = d[4];
    end
    return {c, sum};
  endfunction

  // BCD add that pins the result at 999999 on overflow.
  function automatic logic [23:0] bcd_sat_add(input logic [23:0] a, input logic [23:0] b);
    logic [24:0] r;
    r = bcd_add6(a, b);
    return r[24] ? 24'h999999 : r[23:0];
  endfunction

  // Base points for a clear of n rows, in BCD.
  function automatic logic [23:0] points_bcd(input logic [2:0] n);
    case (n)
      3'd1:    return 24'h000040;
      3'd2:    return 24'h000100;
      3'd3:    return 24'h000300;
      3'd4:    return 24'h001200;
      default: return 24'h000000;
    endcase
  endfunction

  // Request selection, gravity interval and the LEVELUP sums.
  always_comb begin
    w_take = (r_state == S_IDLE) && (r_pend_v || validate_done);
    if (r_pend_v) begin
      w_take_n = r_pend_n;
    end else begin
      w_take_n = lines_cleared;
    end
    w_take_scores = (w_take_n != 3'd0) && (w_take_n <= 3'd4);

    w_level_dec = 32'(r_level) * STEP_INTERVAL;
    if (soft_drop) begin
      w_interval = SOFT_INTERVAL;
    end else if (BASE_INTERVAL >= w_level_dec + MIN_INTERVAL) begin
      w_interval = BASE_INTERVAL - w_level_dec;
    end else begin
      w_interval = MIN_INTERVAL;
    end
    // >= rather than == so a shrinking interval never skips a tick
    w_tick_hit = game_active && (32'(r_grav_cnt) >= (w_interval - 32'd1));

    w_lines_sum = {1'b0, r_lines} + {8'd0, r_n};
    w_lil_sum   = r_lil + LIL_W'(r_n);

`ifdef SOFT_DROP_SCORE_EN
    w_soft_pt = w_tick_hit && soft_drop && (r_state == S_IDLE) && !w_take;
`else
    w_soft_pt = 1'b0;
`endif
  end

  // Scoring FSM with its pending slot and the score/lines/level registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_n          <= 3'd0;
      r_rep        <= 5'd0;
      r_addend     <= 24'h000000;
      r_score      <= 24'h000000;
      r_lines      <= 10'd0;
      r_level      <= 4'd0;
      r_lil        <= '0;
      r_pend_v     <= 1'b0;
      r_pend_n     <= 3'd0;
      r_busy       <= 1'b0;
      r_score_done <= 1'b0;
    end else if (new_game) begin
      r_state      <= S_IDLE;
      r_n          <= 3'd0;
      r_rep        <= 5'd0;
      r_score      <= 24'h000000;
      r_lines      <= 10'd0;
      r_level      <= 4'd0;
      r_lil        <= '0;
      r_pend_v     <= 1'b0;
      r_pend_n     <= 3'd0;
      r_busy       <= 1'b0;
      r_score_done <= 1'b0;
    end else begin
      r_score_done <= 1'b0;
      // While working, park one request; any further request is dropped.
      if ((r_state != S_IDLE) && validate_done && !r_pend_v) begin
        r_pend_v <= 1'b1;
        r_pend_n <= lines_cleared;
      end
      case (r_state)
        S_IDLE: begin
          if (w_take) begin
            r_n <= w_take_n;
            if (r_pend_v) begin
              // pending entry goes first; a same-cycle pulse takes its slot
              r_pend_v <= validate_done;
              r_pend_n <= lines_cleared;
            end
            if (w_take_scores) begin
              r_state <= S_LOAD;
            end else begin
              r_score_done <= 1'b1;
            end
          end else if (w_soft_pt) begin
            r_score <= bcd_sat_add(r_score, 24'h000001);
          end
        end
        S_LOAD: begin
          r_rep    <= {1'b0, r_level} + 5'd1;
          r_addend <= points_bcd(r_n);
          r_busy   <= 1'b1;
          r_state  <= S_ADD;
        end
        S_ADD: begin
          r_score <= bcd_sat_add(r_score, r_addend);
          r_rep   <= r_rep - 5'd1;
          if (r_rep == 5'd1) begin
            r_state <= S_LEVELUP;
          end
        end
        S_LEVELUP: begin
          r_lines <= (w_lines_sum > 11'd999) ? 10'd999 : w_lines_sum[9:0];
          if (w_lil_sum >= LIL_W'(LINES_PER_LEVEL)) begin
            r_lil <= w_lil_sum - LIL_W'(LINES_PER_LEVEL);
            if (r_level != 4'(MAX_LEVEL)) begin
              r_level <= r_level + 4'd1;
            end
          end else begin
            r_lil <= w_lil_sum;
          end
          r_score_done <= 1'b1;
          r_busy       <= 1'b0;
          r_state      <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Gravity counter and registered tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_grav_cnt <= '0;
      r_tick     <= 1'b0;
    end else if (new_game || !game_active) begin
      r_grav_cnt <= '0;
      r_tick     <= 1'b0;
    end else if (w_tick_hit) begin
      r_grav_cnt <= '0;
      r_tick     <= 1'b1;
    end else begin
      r_grav_cnt <= r_grav_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      r_tick     <= 1'b0;
    end
  end

  assign score_bcd    = r_score;
  assign total_lines  = r_lines;
  assign level        = r_level;
  assign gravity_tick = r_tick;
  assign busy         = r_busy;
  assign score_done   = r_score_done;

endmodule
